// File: rtl/instr_byte_loader_pkg.sv
// Shared constants for the instruction byte loader: word geometry and default FIFO depth.
package instr_byte_loader_pkg;

    localparam int INSTR_W        = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int DEPTH_DEFAULT  = 4;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    typedef logic [IDX_W-1:0] byte_idx_t;

endpackage

// File: rtl/instr_byte_loader_fifo.sv
// Word FIFO behind the byte packer: registered storage, wrap-around pointers, flush clears state.
module loader_fifo
    import instr_byte_loader_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push,
    input  logic [INSTR_W-1:0] wdata,
    input  logic               pop,
    output logic [INSTR_W-1:0] rdata,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_en;
    logic               pop_en;

    always_comb begin
        pop_en   = pop && (count_q != '0);
        // A full FIFO still accepts a write when the head leaves on the same edge.
        push_en  = push && ((count_q != FULL_CNT) || pop_en);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_en && !pop_en)      count_d = count_q + CNT_W'(1);
            else if (pop_en && !push_en) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en && !flush) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

endmodule

// File: rtl/instr_byte_loader.sv
// Collects strobed host bytes into little-endian 32-bit words and queues them for the core.
module instr_byte_loader
    import instr_byte_loader_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BYTE_W-1:0]          byte_in,
    input  logic                       byte_stb,
    input  logic                       flush,
    output logic [INSTR_W-1:0]         instr_data,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [IDX_W-1:0]           byte_idx,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow
);

    localparam int LANES_W = INSTR_W - BYTE_W;

    logic               stb_q, stb_d;
    byte_idx_t          byte_idx_q, byte_idx_d;
    logic               overflow_q, overflow_d;
    logic [LANES_W-1:0] lanes_q, lanes_d;
    logic               accept;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [INSTR_W-1:0] push_data;

    always_comb begin
        accept     = byte_stb && !stb_q;
        push       = accept && (byte_idx_q == byte_idx_t'(BYTES_PER_WORD - 1));
        pop        = instr_ready && !fifo_empty;
        // The last lane comes straight from byte_in so the word is pushed on its final edge.
        push_data  = {byte_in, lanes_q};
        stb_d      = byte_stb;
        byte_idx_d = byte_idx_q;
        overflow_d = overflow_q;
        lanes_d    = lanes_q;
        if (flush) begin
            byte_idx_d = '0;
            overflow_d = 1'b0;
        end else if (accept) begin
            byte_idx_d = byte_idx_q + byte_idx_t'(1);
            case (byte_idx_q)
                2'd0:    lanes_d[7:0]   = byte_in;
                2'd1:    lanes_d[15:8]  = byte_in;
                2'd2:    lanes_d[23:16] = byte_in;
                default: lanes_d        = lanes_q;
            endcase
            if (push && fifo_full && !pop) overflow_d = 1'b1;
        end
    end

    // stb_q resets high so a strobe held through reset cannot look like a fresh edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            stb_q      <= 1'b1;
            byte_idx_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            stb_q      <= stb_d;
            byte_idx_q <= byte_idx_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        lanes_q <= lanes_d;
    end

    loader_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .wdata (push_data),
        .pop   (pop),
        .rdata (instr_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign instr_valid = !fifo_empty;
    assign byte_idx    = byte_idx_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_instr_byte_loader.sv
// Directed bench for instr_byte_loader with hand-computed expected words and flags.
module tb_instr_byte_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  byte_in;
    logic        byte_stb;
    logic        flush;
    logic [31:0] instr_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  byte_idx;
    logic [2:0]  fifo_count;
    logic        overflow;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] words [5] = '{32'h11223344, 32'h55667788, 32'h99AABBCC,
                               32'hDDEEFF00, 32'h0BADF00D};

    always #5 clk = ~clk;

    instr_byte_loader #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .byte_in     (byte_in),
        .byte_stb    (byte_stb),
        .flush       (flush),
        .instr_data  (instr_data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .byte_idx    (byte_idx),
        .fifo_count  (fifo_count),
        .overflow    (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe_byte(input logic [7:0] b);
        byte_in  = b;
        byte_stb = 1'b1;
        tick();
        byte_stb = 1'b0;
        tick();
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) strobe_byte(w[8*i +: 8]);
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] w);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
        chk({tag, "_data"}, instr_data, w);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; byte_in = 8'h00; byte_stb = 1'b0; flush = 1'b0; instr_ready = 1'b0;
        tick(); tick();
        chk("rst_idx", 32'(byte_idx), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        tick();

        // First word and its latency.
        strobe_byte(8'h13); strobe_byte(8'h05); strobe_byte(8'h10);
        chk("w0_idx3", 32'(byte_idx), 32'd3);
        chk("w0_notyet", 32'(instr_valid), 32'd0);
        byte_in = 8'h00; byte_stb = 1'b1;
        tick();
        chk("w0_valid", 32'(instr_valid), 32'd1);
        chk("w0_data", instr_data, 32'h00100513);
        chk("w0_count", 32'(fifo_count), 32'd1);
        chk("w0_idx0", 32'(byte_idx), 32'd0);
        byte_stb = 1'b0;
        tick();
        instr_ready = 1'b1;
        tick();
        chk("pop0_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("pop_empty_count", 32'(fifo_count), 32'd0);
        instr_ready = 1'b0;

        // Held strobe counts once.
        byte_in = 8'hAA; byte_stb = 1'b1;
        tick();
        byte_in = 8'h55;
        repeat (4) tick();
        chk("held_idx1", 32'(byte_idx), 32'd1);
        byte_stb = 1'b0;
        tick();
        strobe_byte(8'hBB); strobe_byte(8'hCC); strobe_byte(8'hDD);
        chk("held_idx0", 32'(byte_idx), 32'd0);
        chk("held_count", 32'(fifo_count), 32'd1);
        pop_expect("held", 32'hDDCCBBAA);

        // Overflow: fifth word dropped, first four kept in order.
        for (int i = 0; i < 5; i++) push_word(words[i]);
        chk("ovf_count", 32'(fifo_count), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_idx", 32'(byte_idx), 32'd0);
        for (int i = 0; i < 4; i++) pop_expect($sformatf("ovf_pop%0d", i), words[i]);
        chk("ovf_drained", 32'(instr_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("ovf_flushed", 32'(overflow), 32'd0);

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 4; i++) push_word(words[i]);
        for (int i = 0; i < 3; i++) strobe_byte(words[4][8*i +: 8]);
        byte_in = words[4][31:24]; byte_stb = 1'b1; instr_ready = 1'b1;
        tick();
        byte_stb = 1'b0; instr_ready = 1'b0;
        chk("fullpp_count", 32'(fifo_count), 32'd4);
        chk("fullpp_ovf", 32'(overflow), 32'd0);
        tick();
        for (int i = 1; i < 5; i++) pop_expect($sformatf("fullpp_pop%0d", i), words[i]);
        chk("fullpp_empty", 32'(fifo_count), 32'd0);

        // Flush with a partial word and a queued word.
        push_word(words[0]);
        strobe_byte(8'h77); strobe_byte(8'h66);
        chk("fl_idx2", 32'(byte_idx), 32'd2);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("fl_idx", 32'(byte_idx), 32'd0);
        chk("fl_valid", 32'(instr_valid), 32'd0);
        chk("fl_count", 32'(fifo_count), 32'd0);
        push_word(32'hCAFEBABE);
        chk("fl_clean_count", 32'(fifo_count), 32'd1);
        chk("fl_clean_data", instr_data, 32'hCAFEBABE);

        // Push and pop on the same edge at fill level 1.
        for (int i = 0; i < 3; i++) strobe_byte(words[1][8*i +: 8]);
        byte_in = words[1][31:24]; byte_stb = 1'b1; instr_ready = 1'b1;
        tick();
        byte_stb = 1'b0; instr_ready = 1'b0;
        chk("pp1_count", 32'(fifo_count), 32'd1);
        tick();
        pop_expect("pp1", words[1]);

        // Reset mid-word with strobe held high.
        push_word(words[2]);
        strobe_byte(8'h01); strobe_byte(8'h02);
        byte_in = 8'hEE; byte_stb = 1'b1; rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        chk("rstmid_idx", 32'(byte_idx), 32'd0);
        chk("rstmid_count", 32'(fifo_count), 32'd0);
        chk("rstmid_valid", 32'(instr_valid), 32'd0);
        chk("rstmid_ovf", 32'(overflow), 32'd0);
        byte_stb = 1'b0;
        tick();
        push_word(32'h12345678);
        chk("rstmid_count1", 32'(fifo_count), 32'd1);
        chk("rstmid_data", instr_data, 32'h12345678);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
